// File: rtl/inst_pkg.sv
// Shared definitions for the 8-bit instruction interface: opcodes, field positions
// and per-opcode register usage.
package inst_pkg;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SET  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  // LSB of each 2-bit field inside an instruction byte
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_LSB = 2;
  localparam int unsigned RD_LSB  = 0;

  function automatic logic reads_rs1(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_NAND);
  endfunction

  function automatic logic reads_rs2(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_NAND);
  endfunction

  function automatic logic writes_rd(input logic [1:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// DEPTH x 8 instruction FIFO: storage, wrapping pointers and occupancy count.
// The caller guarantees no push when full and no pop when empty.
module inst_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  // Occupancy next state; simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer and count registers; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

endmodule

// File: rtl/inst_issue.sv
// Instruction issue unit: buffers host instructions and issues them to the pipeline,
// holding any instruction whose source register still has a write in flight.
// Optional macro INST_ISSUE_NOP_FILL_EN keeps out_valid high and fills stalls with NOPs.
module inst_issue
  import inst_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WB_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_inst,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_inst,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             busy,
  output logic [$clog2(DEPTH):0] count
);

  logic [7:0] head;
  logic       empty, full;
  logic       push, pop;
  logic [1:0] op, rs1, rs2, rd;
  logic       hazard, issuable, issue_wr;
  logic [2:0] cnt_q [4];
  logic [2:0] cnt_d [4];

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  inst_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_inst),
    .rdata (head),
    .empty (empty),
    .full  (full),
    .count (count)
  );

  assign op  = head[OP_LSB  +: 2];
  assign rs1 = head[RS1_LSB +: 2];
  assign rs2 = head[RS2_LSB +: 2];
  assign rd  = head[RD_LSB  +: 2];

  // Busy flags and head hazard detection
  always_comb begin
    for (int i = 0; i < 4; i++) busy[i] = (cnt_q[i] != 3'd0);
    hazard   = (reads_rs1(op) && busy[rs1]) || (reads_rs2(op) && busy[rs2]);
    issuable = !empty && !hazard;
  end

  assign pop      = issuable && out_ready;
  assign issue_wr = pop && writes_rd(op);

  // Output mux: with NOP fill, stalls present a valid NOP instead of dropping valid
  always_comb begin
`ifdef INST_ISSUE_NOP_FILL_EN
    out_valid = 1'b1;
    out_inst  = issuable ? head : 8'h00;
`else
    out_valid = issuable;
    out_inst  = empty ? 8'h00 : head;
`endif
  end

  // Scoreboard next state: reload on issue to rd, otherwise count down to zero
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      if (issue_wr && (rd == 2'(i))) begin
        cnt_d[i] = 3'(WB_LAT);
      end else if (cnt_q[i] != 3'd0) begin
        cnt_d[i] = cnt_q[i] - 3'd1;
      end
    end
  end

  // Scoreboard counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 3'd0;
    end else begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule

// File: tb/tb_inst_issue.sv
// Self-checking bench for inst_issue (DEPTH=4, WB_LAT=2). Expected issue order is
// queued at push time and compared by an independent monitor at each real issue.
module tb_inst_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_inst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_inst;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] busy;
  logic [2:0] count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  logic [7:0] exp_q[$];
  int         iss_cyc[$];

  inst_issue #(
    .DEPTH  (4),
    .WB_LAT (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_inst   (in_inst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_inst  (out_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .count     (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] inst);
    in_valid = 1'b1;
    in_inst  = inst;
    exp_q.push_back(inst);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((count != 3'd0 || busy != 4'd0) && n < 30) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, (n >= 30)}, 32'd0);
  endtask

  // Monitor: every real (non-NOP) issue must match the next queued instruction
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready && out_inst != 8'h00) begin
      iss_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_issue", {24'd0, out_inst}, 32'hFFFF);
      end else begin
        check("issue_order", {24'd0, out_inst}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    int acc;
    logic [7:0] fill_v [5];
    fill_v[0] = 8'h84; fill_v[1] = 8'h85; fill_v[2] = 8'h86;
    fill_v[3] = 8'h87; fill_v[4] = 8'h88;

    rst = 1'b1; in_valid = 1'b0; in_inst = 8'h00; out_ready = 1'b0;
    #1;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_busy", {28'd0, busy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef INST_ISSUE_NOP_FILL_EN
    check("rst_out_valid", {31'd0, out_valid}, 32'd1);
`else
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
`endif
    check("rst_out_inst", {24'd0, out_inst}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Empty FIFO output over several cycles
    for (int i = 0; i < 3; i++) begin
`ifdef INST_ISSUE_NOP_FILL_EN
      check("empty_valid", {31'd0, out_valid}, 32'd1);
`else
      check("empty_valid", {31'd0, out_valid}, 32'd0);
`endif
      check("empty_inst", {24'd0, out_inst}, 32'd0);
      tick();
    end

    // Mid-stream reset with 3 entries queued and a write in flight
    push_one(8'h5B); push_one(8'h84); push_one(8'hC6);
    check("mid_count3", {29'd0, count}, 32'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("mid_busy", {28'd0, busy}, 32'h8);
    check("mid_count2", {29'd0, count}, 32'd2);
    push_one(8'hC7);
    check("mid_count3b", {29'd0, count}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_count", {29'd0, count}, 32'd0);
    check("mid_rst_busy", {28'd0, busy}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef INST_ISSUE_NOP_FILL_EN
    check("mid_rst_valid", {31'd0, out_valid}, 32'd1);
`else
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
`endif
    check("mid_rst_inst", {24'd0, out_inst}, 32'd0);
    tick();
    rst = 1'b0;
    exp_q.delete();
    tick();

    // Fill: 5 offered with out_ready low, only 4 accepted
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_inst  = fill_v[i];
      if (in_ready) acc++;
      if (i < 4) exp_q.push_back(fill_v[i]);
      tick();
    end
    in_valid = 1'b0;
    check("fill_accepted", acc, 32'd4);
    check("fill_in_ready", {31'd0, in_ready}, 32'd0);
    check("fill_count", {29'd0, count}, 32'd4);
    out_ready = 1'b1;
    check("fill_pop_cycle_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("fill_after_pop_ready", {31'd0, in_ready}, 32'd1);
    check("fill_after_pop_count", {29'd0, count}, 32'd3);
    wait_idle();
    tick();

    // Hazard: ADD r3<-r1+r2 then ADD r0<-r3+r0
    iss_cyc.delete();
    in_valid = 1'b1; in_inst = 8'h5B; exp_q.push_back(8'h5B);
    tick();
    in_inst = 8'h70; exp_q.push_back(8'h70);
    check("haz_t_inst", {24'd0, out_inst}, 32'h5B);
    check("haz_t_valid", {31'd0, out_valid}, 32'd1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      check("haz_busy", {28'd0, busy}, 32'h8);
`ifdef INST_ISSUE_NOP_FILL_EN
      check("haz_bubble_valid", {31'd0, out_valid}, 32'd1);
      check("haz_bubble_inst", {24'd0, out_inst}, 32'h00);
`else
      check("haz_hold_valid", {31'd0, out_valid}, 32'd0);
`endif
      tick();
    end
    check("haz_t3_busy", {28'd0, busy}, 32'h0);
    check("haz_t3_valid", {31'd0, out_valid}, 32'd1);
    check("haz_t3_inst", {24'd0, out_inst}, 32'h70);
    tick();
    check("haz_issue_n", iss_cyc.size(), 32'd2);
    if (iss_cyc.size() == 2) check("haz_spacing", iss_cyc[1] - iss_cyc[0], 32'd3);
    wait_idle();

    // Independent: ADD then SET issue back to back
    iss_cyc.delete();
    in_valid = 1'b1; in_inst = 8'h5B; exp_q.push_back(8'h5B);
    tick();
    in_inst = 8'h84; exp_q.push_back(8'h84);
    tick();
    in_valid = 1'b0;
    tick();
    check("ind_busy", {28'd0, busy}, 32'h9);
    check("ind_issue_n", iss_cyc.size(), 32'd2);
    if (iss_cyc.size() == 2) check("ind_spacing", iss_cyc[1] - iss_cyc[0], 32'd1);
    wait_idle();

    // Backpressure: NAND held at head for 5 cycles
    out_ready = 1'b0;
    push_one(8'hC6);
    for (int k = 0; k < 5; k++) begin
      check("bp_inst", {24'd0, out_inst}, 32'hC6);
      check("bp_count", {29'd0, count}, 32'd1);
      tick();
    end
    in_valid = 1'b1; in_inst = 8'h84; exp_q.push_back(8'h84);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("bp_pushpop_count", {29'd0, count}, 32'd1);
    check("bp_next_head", {24'd0, out_inst}, 32'h84);
    wait_idle();
    tick();

    check("all_issued", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
